shift_register_universal: RTL
=============================

Name: shift_register_universal

Overview:
- Parametrised successor to the single-bit D flip-flop with async reset, sync reset and enable.
- WIDTH-bit universal shift register with mode-selected hold, parallel load, logical shift, rotate, arithmetic shift and clear.
- Carries the same reset_sync/enable priority scheme and adds a shift counter with a wrap pulse, so it can serve as a serialiser/deserialiser front end in the sequential-blocks library.

Parameters:
- WIDTH, 8: register width in bits; legal range WIDTH >= 2.
- RESET_VALUE, {WIDTH{1'b0}}: value loaded into q by async reset, by sync reset and by mode CLEAR.

Ports:
- clk  in  1  rising-edge clock.
- reset_async_n  in  1  asynchronous reset, active-low.
- reset_sync  in  1  synchronous reset, active-high; overrides enable.
- enable  in  1  when 0, q and the counter hold (reset_sync still acts).
- mode  in  3  operation select; encodings are listed under Behaviour.
- d  in  WIDTH  parallel load data.
- serial_in  in  1  fill bit for SHL/SHR.
- q  out  WIDTH  register contents.
- serial_out_msb  out  1  combinational, equals q[WIDTH-1].
- serial_out_lsb  out  1  combinational, equals q[0].
- shift_count  out  CW=$clog2(WIDTH)  number of shift/rotate ops since last load/clear, modulo WIDTH.
- pass_done  out  1  registered one-cycle pulse after the WIDTH-th shift/rotate.

Behaviour:
- Async reset (reset_async_n=0): immediately, independent of clk, q=RESET_VALUE, shift_count=0, pass_done=0. Held as long as low; release is synchronous-safe (no action until the next clk edge).
- Priority on each rising clk edge: reset_sync > enable==0 > mode.
- reset_sync=1: q=RESET_VALUE, shift_count=0, pass_done=0. Applies regardless of enable and mode.
- enable=0 (and reset_sync=0): q and shift_count hold; pass_done=0.
- Modes (enable=1):
  - 0 HOLD: q unchanged.
  - 1 LOAD: q=d.
  - 2 SHL: q={q[WIDTH-2:0],serial_in}.
  - 3 SHR: q={serial_in,q[WIDTH-1:1]}.
  - 4 ROL: q={q[WIDTH-2:0],q[WIDTH-1]}.
  - 5 ROR: q={q[0],q[WIDTH-1:1]}.
  - 6 ASR: q={q[WIDTH-1],q[WIDTH-1:1]}.
  - 7 CLEAR: q=RESET_VALUE.
- Counter rules:
  - Shift ops are modes 2-6. Each enabled shift op increments shift_count.
  - If shift_count==WIDTH-1 at that edge, shift_count wraps to 0 and pass_done=1 for exactly the following cycle.
  - LOAD and CLEAR set shift_count=0 and do not pulse pass_done.
  - HOLD leaves shift_count unchanged.
  - pass_done is 0 in every cycle not directly following a wrap.
- Back-to-back: continuous shifting pulses pass_done once every WIDTH cycles.
- A LOAD on the edge after a wrap does not suppress the pulse already registered.
- Reset mid-pass: any reset discards the partial count; WIDTH further shifts are required for the next pass_done.
- Outputs q, shift_count and pass_done are all registered. serial_out_* are combinational from q only, with no path from inputs.

Decomposition:
- Shared package shift_register_pkg:
  - mode localparams MODE_HOLD..MODE_CLEAR (3-bit).
  - function for counter width (max(1,$clog2(WIDTH))).
- Sub-module shift_pass_counter (params WIDTH):
  - inputs clk, reset_async_n, clr, inc.
  - outputs count, pass_done.
  - holds the modulo-WIDTH counter and the pulse register.
- The top holds the q datapath and mode decode.

Test Plan:
All scenarios use WIDTH=8 and RESET_VALUE=0.
1. Async reset with enable=1, mode=LOAD, d=8'hFF: drive reset_async_n=0 between clk edges -> q=8'h00, shift_count=0, pass_done=0 immediately, and they stay so across edges while low.
2. Basic shifts: LOAD d=8'hA5, then SHL serial_in=1 -> q=8'h4B, count=1; then SHR serial_in=0 -> q=8'h25, count=2; serial_out_lsb=1, serial_out_msb=0.
3. Rotate and pass pulse: LOAD 8'hA5, then ROL for 8 consecutive cycles -> count steps 1..7,0, q returns to 8'hA5, pass_done=1 only in the cycle after the 8th rotate. Repeat with ROR for the same result.
4. Arithmetic shift: LOAD 8'h90, then ASR x2 -> 8'hC8, 8'hE4. LOAD 8'h70, then ASR -> 8'h38.
5. Gating and sync reset: with q=8'h3C, enable=0, mode=SHL -> q and count hold for 5 cycles. Then reset_sync=1 with enable=0 -> q=8'h00, count=0 at the next edge.
6. Reset mid-pass: 5 SHL ops, then pulse reset_async_n low for 3 ns -> count=0. After release, no pass_done until exactly 8 more shifts. Also check that CLEAR at count=7 yields count=0 with no pulse.

Source files
------------

// File: rtl/shift_register_universal_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// helpers used by the top-level datapath, the pass counter and the interface.
package shift_register_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_SHL   = 3'd2;
  localparam logic [2:0] MODE_SHR   = 3'd3;
  localparam logic [2:0] MODE_ROL   = 3'd4;
  localparam logic [2:0] MODE_ROR   = 3'd5;
  localparam logic [2:0] MODE_ASR   = 3'd6;
  localparam logic [2:0] MODE_CLEAR = 3'd7;

  // Width of the shift counter; never narrower than one bit.
  function automatic int count_width(input int width);
    int cw;
    cw = $clog2(width);
    return (cw < 1) ? 1 : cw;
  endfunction

  // Modes SHL..ASR move bits and therefore advance the pass counter.
  function automatic logic is_shift_mode(input logic [2:0] mode);
    return (mode >= MODE_SHL) && (mode <= MODE_ASR);
  endfunction

  // Modes that restart the pass counter.
  function automatic logic is_restart_mode(input logic [2:0] mode);
    return (mode == MODE_LOAD) || (mode == MODE_CLEAR);
  endfunction

endpackage

// File: rtl/shift_register_universal_if.sv
// Control/data bundle of the universal shift register. The master side
// drives controls and data; the slave side is the register itself.
interface shift_register_universal_if
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 8
);

  localparam int CW = count_width(WIDTH);

  logic             reset_sync;
  logic             enable;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             serial_out_msb;
  logic             serial_out_lsb;
  logic [CW-1:0]    shift_count;
  logic             pass_done;

  modport master (
    output reset_sync, enable, mode, d, serial_in,
    input  q, serial_out_msb, serial_out_lsb, shift_count, pass_done
  );

  modport slave (
    input  reset_sync, enable, mode, d, serial_in,
    output q, serial_out_msb, serial_out_lsb, shift_count, pass_done
  );

endinterface

// File: rtl/shift_register_universal_pass_counter.sv
// Modulo-WIDTH shift counter with a registered one-cycle pulse emitted in
// the cycle after the counter wraps from WIDTH-1 back to 0.
module shift_pass_counter
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_async_n,
  input  logic                        clr,
  input  logic                        inc,
  output logic [count_width(WIDTH)-1:0] count,
  output logic                        pass_done
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Count shift ops; restart on clr; pulse pass_done for one cycle on wrap.
  always_ff @(posedge clk or negedge reset_async_n) begin
    if (!reset_async_n) begin
      count     <= '0;
      pass_done <= 1'b0;
    end else if (clr) begin
      count     <= '0;
      pass_done <= 1'b0;
    end else if (inc) begin
      if (count == LAST) begin
        count     <= '0;
        pass_done <= 1'b1;
      end else begin
        count     <= count + 1'b1;
        pass_done <= 1'b0;
      end
    end else begin
      pass_done <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_register_universal.sv
// WIDTH-bit universal shift register: hold, load, logical shifts, rotates,
// arithmetic shift right and clear, with a pass counter so it can front a
// serialiser/deserialiser. Priority: reset_sync > enable==0 > mode.
module shift_register_universal
  import shift_register_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         reset_async_n,
  shift_register_universal_if.slave    bus
);

  logic [WIDTH-1:0]        q_reg;
  logic [WIDTH-1:0]        q_next;
  logic signed [WIDTH-1:0] q_signed;
  logic                    cnt_clr;
  logic                    cnt_inc;

  assign q_signed = q_reg;

  // Mode decode: next register contents when the register is enabled.
  always_comb begin
    q_next = q_reg;
    case (bus.mode)
      MODE_HOLD:  q_next = q_reg;
      MODE_LOAD:  q_next = bus.d;
      MODE_SHL:   q_next = {q_reg[WIDTH-2:0], bus.serial_in};
      MODE_SHR:   q_next = {bus.serial_in, q_reg[WIDTH-1:1]};
      MODE_ROL:   q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
      MODE_ROR:   q_next = {q_reg[0], q_reg[WIDTH-1:1]};
      MODE_ASR:   q_next = q_signed >>> 1;
      MODE_CLEAR: q_next = RESET_VALUE;
      default:    q_next = q_reg;
    endcase
  end

  // Register update: sync reset wins over enable, enable gates every mode.
  always_ff @(posedge clk or negedge reset_async_n) begin
    if (!reset_async_n) begin
      q_reg <= RESET_VALUE;
    end else if (bus.reset_sync) begin
      q_reg <= RESET_VALUE;
    end else if (bus.enable) begin
      q_reg <= q_next;
    end
  end

  assign cnt_clr = bus.reset_sync | (bus.enable & is_restart_mode(bus.mode));
  assign cnt_inc = bus.enable & is_shift_mode(bus.mode);

  shift_pass_counter #(
    .WIDTH (WIDTH)
  ) u_pass_counter (
    .clk           (clk),
    .reset_async_n (reset_async_n),
    .clr           (cnt_clr),
    .inc           (cnt_inc),
    .count         (bus.shift_count),
    .pass_done     (bus.pass_done)
  );

  assign bus.q              = q_reg;
  assign bus.serial_out_msb = q_reg[WIDTH-1];
  assign bus.serial_out_lsb = q_reg[0];

endmodule
